// File: rtl/input_port_buffer_pkg.sv
// Shared types and field-position helpers for the router input port buffer.
package input_port_buffer_pkg;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ROUTE  = 2'b01,
        ACTIVE = 2'b10
    } ibuf_state_e;

    localparam int TYPE_W    = 2;
    localparam int DST_X_LSB = 0;

    // The type field occupies the top two bits of every flit.
    function automatic int type_lsb(input int flit_width);
        return flit_width - TYPE_W;
    endfunction

    function automatic int dst_y_lsb(input int x_width);
        return x_width + 1;
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/input_port_buffer_if.sv
// Flit, credit and route-computation signals of one router input port.
interface input_port_buffer_if #(
    parameter int X_WIDTH    = 2,
    parameter int Y_WIDTH    = 2,
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                     in_valid;
    logic [FLIT_WIDTH-1:0]    in_flit;
    logic                     credit_out;
    logic [X_WIDTH:0]         dst_x;
    logic [Y_WIDTH:0]         dst_y;
    logic                     dst_valid;
    logic                     out_valid;
    logic [FLIT_WIDTH-1:0]    out_flit;
    logic                     out_ready;
    logic                     out_tail;
    logic [$clog2(DEPTH):0]   count;
    logic                     err;

    // master: upstream link plus switch side; slave: the buffer itself
    modport master (
        output in_valid, in_flit, out_ready,
        input  credit_out, dst_x, dst_y, dst_valid, out_valid, out_flit,
               out_tail, count, err
    );

    modport slave (
        input  in_valid, in_flit, out_ready,
        output credit_out, dst_x, dst_y, dst_valid, out_valid, out_flit,
               out_tail, count, err
    );
endinterface

// File: rtl/input_port_buffer_sync_fifo.sv
// Synchronous FIFO with a registered front word; a write appears at the front one cycle later.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] front_reg;
    logic             push;
    logic             pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = rd_en && !empty;
    // A full FIFO still accepts a write when a slot is freed in the same cycle.
    assign push  = wr_en && (!full || pop);
    assign rd_ptr_next = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            front_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            // Bypass covers the word being written into the slot that becomes the front.
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                front_reg <= wr_data;
            end else begin
                front_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rd_data = front_reg;
    assign count   = count_reg;
endmodule

// File: rtl/input_port_buffer.sv
// Router input port: credit-managed flit FIFO, per-packet destination latch for rc,
// and the IDLE/ROUTE/ACTIVE sequencer that gates flits towards switch traversal.
module input_port_buffer
    import input_port_buffer_pkg::*;
#(
    parameter int X_WIDTH    = 2,
    parameter int Y_WIDTH    = 2,
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input_port_buffer_if.slave   bus
);
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int TYPE_LSB = type_lsb(FLIT_WIDTH);
    localparam int DY_LSB   = dst_y_lsb(X_WIDTH);

    logic [FLIT_WIDTH-1:0] front;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    flit_type_e            front_type;

    ibuf_state_e           state_reg;
    ibuf_state_e           state_next;
    logic                  out_valid;
    logic                  switch_pop;
    logic                  drop_pop;
    logic                  fifo_pop;
    logic                  capture;
    logic                  release_pkt;
    logic                  overflow;

    logic [X_WIDTH:0]      dst_x_reg;
    logic [Y_WIDTH:0]      dst_y_reg;
    logic                  dst_valid_reg;
    logic                  credit_reg;
    logic                  err_reg;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_data (bus.in_flit),
        .rd_en   (fifo_pop),
        .rd_data (front),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign front_type = flit_type_e'(front[TYPE_LSB +: TYPE_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        out_valid   = 1'b0;
        switch_pop  = 1'b0;
        drop_pop    = 1'b0;
        capture     = 1'b0;
        release_pkt = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    if (is_head(front_type)) begin
                        capture    = 1'b1;
                        state_next = ROUTE;
                    end else begin
                        // Orphan body/tail without a head: discard but still return its credit.
                        drop_pop = 1'b1;
                    end
                end
            end
            ROUTE: begin
                state_next = ACTIVE;
            end
            ACTIVE: begin
                out_valid  = !fifo_empty;
                switch_pop = out_valid && bus.out_ready;
                if (switch_pop && is_tail(front_type)) begin
                    release_pkt = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fifo_pop = switch_pop || drop_pop;
    assign overflow = bus.in_valid && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_x_reg     <= '0;
            dst_y_reg     <= '0;
            dst_valid_reg <= 1'b0;
            credit_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (capture) begin
                dst_x_reg     <= front[DST_X_LSB +: X_WIDTH+1];
                dst_y_reg     <= front[DY_LSB +: Y_WIDTH+1];
                dst_valid_reg <= 1'b1;
            end else if (release_pkt) begin
                dst_valid_reg <= 1'b0;
            end
            credit_reg <= fifo_pop;
            if (overflow || drop_pop) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.credit_out = credit_reg;
    assign bus.dst_x      = dst_x_reg;
    assign bus.dst_y      = dst_y_reg;
    assign bus.dst_valid  = dst_valid_reg;
    assign bus.out_valid  = out_valid;
    assign bus.out_flit   = front;
    assign bus.out_tail   = is_tail(front_type);
    assign bus.count      = fifo_count;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_input_port_buffer.sv
// Scoreboard bench for input_port_buffer: expected flits queued at push, checked at switch pop.
module tb_input_port_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;
    int credit_cnt   = 0;

    logic [31:0] exp_q [$];
    logic [2:0]  cur_dx = '0;
    logic [2:0]  cur_dy = '0;

    input_port_buffer_if #(.X_WIDTH(2), .Y_WIDTH(2), .FLIT_WIDTH(32), .DEPTH(4)) bus ();

    input_port_buffer #(.X_WIDTH(2), .Y_WIDTH(2), .FLIT_WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] dx,
                                       input logic [2:0] dy, input logic [23:0] pl);
        return {t, pl, dy, dx};
    endfunction

    // One clock: observe the switch side at negedge, then step to just after the next posedge.
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (bus.credit_out === 1'b1) credit_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_flit: got %h, scoreboard empty", bus.out_flit);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_flit !== e) begin
                    tests_failed++;
                    $display("FAIL flit_data: got %h expected %h", bus.out_flit, e);
                end
                if (e[31:30] == 2'b01 || e[31:30] == 2'b11) begin
                    cur_dx = e[2:0];
                    cur_dy = e[5:3];
                end
                tests_run++;
                if ({bus.dst_valid, bus.dst_x, bus.dst_y} !== {1'b1, cur_dx, cur_dy}) begin
                    tests_failed++;
                    $display("FAIL dst_hold: got v=%b x=%0d y=%0d expected v=1 x=%0d y=%0d",
                             bus.dst_valid, bus.dst_x, bus.dst_y, cur_dx, cur_dy);
                end
                tests_run++;
                if (bus.out_tail !== e[31]) begin
                    tests_failed++;
                    $display("FAIL out_tail: got %b expected %b", bus.out_tail, e[31]);
                end
                $display("[TB] pop flit %h dst=(%0d,%0d)", e, cur_dx, cur_dy);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] f, input bit accepted);
        bus.in_valid = 1'b1;
        bus.in_flit  = f;
        if (accepted) exp_q.push_back(f);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            cyc();
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d flits left, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.credit_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fifo: count=%0d out_valid=%b credit=%b required 0/0/0",
                     bus.count, bus.out_valid, bus.credit_out);
        end
        tests_run++;
        if ({bus.dst_valid, bus.dst_x, bus.dst_y, bus.err} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_dst: v=%b x=%0d y=%0d err=%b required all 0",
                     bus.dst_valid, bus.dst_x, bus.dst_y, bus.err);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_flit();
        bus.out_ready = 1'b1;
        push(mk(2'b11, 3'd3, 3'd1, 24'hA5A5A5), 1'b1);
        tests_run++;
        if (bus.dst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_dst_early: dst_valid=%b at T+1 required 0", bus.dst_valid);
        end
        cyc();
        tests_run++;
        if ({bus.dst_valid, bus.dst_x, bus.dst_y, bus.out_valid} !== {1'b1, 3'd3, 3'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL t1_dst_T2: v=%b x=%0d y=%0d ov=%b required 1,3,1,0",
                     bus.dst_valid, bus.dst_x, bus.dst_y, bus.out_valid);
        end
        cyc();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.credit_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_out_T3: out_valid=%b credit=%b required 1/0", bus.out_valid, bus.credit_out);
        end
        cyc();
        tests_run++;
        if ({bus.credit_out, bus.out_valid, bus.dst_valid, bus.count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL t1_T4: credit=%b ov=%b dv=%b count=%0d required 1,0,0,0",
                     bus.credit_out, bus.out_valid, bus.dst_valid, bus.count);
        end
        cyc();
        $display("[TB] single head_tail done");
    endtask

    task automatic test_packet();
        int c0 = credit_cnt;
        bus.out_ready = 1'b1;
        push(mk(2'b01, 3'd1, 3'd2, 24'h000011), 1'b1);
        push(mk(2'b00, 3'd5, 3'd6, 24'h000022), 1'b1);
        push(mk(2'b00, 3'd7, 3'd4, 24'h000033), 1'b1);
        push(mk(2'b10, 3'd0, 3'd0, 24'h000044), 1'b1);
        drain(20);
        cyc();
        cyc();
        tests_run++;
        if (credit_cnt - c0 != 4) begin
            tests_failed++;
            $display("FAIL t2_credits: got %0d pulses required 4", credit_cnt - c0);
        end
        tests_run++;
        if ({bus.dst_valid, bus.dst_x, bus.dst_y, bus.count} !== {1'b0, 3'd1, 3'd2, 3'd0}) begin
            tests_failed++;
            $display("FAIL t2_after_tail: v=%b x=%0d y=%0d count=%0d required 0,1,2,0",
                     bus.dst_valid, bus.dst_x, bus.dst_y, bus.count);
        end
        $display("[TB] 4-flit packet done");
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        push(mk(2'b01, 3'd2, 3'd2, 24'h000101), 1'b1);
        push(mk(2'b00, 3'd0, 3'd0, 24'h000102), 1'b1);
        push(mk(2'b00, 3'd0, 3'd0, 24'h000103), 1'b1);
        push(mk(2'b00, 3'd0, 3'd0, 24'h000104), 1'b1);
        push(mk(2'b00, 3'd0, 3'd0, 24'h0001FF), 1'b0);
        tests_run++;
        if (bus.count !== 3'd4 || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL t3_overflow: count=%0d err=%b required 4/1", bus.count, bus.err);
        end
        bus.out_ready = 1'b1;
        push(mk(2'b10, 3'd0, 3'd0, 24'h000105), 1'b1);
        tests_run++;
        if (bus.count !== 3'd4 || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL t3_full_pushpop: count=%0d err=%b required 4/1", bus.count, bus.err);
        end
        drain(20);
        cyc();
        tests_run++;
        if (bus.count !== 3'd0 || bus.dst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_drained: count=%0d dv=%b required 0/0", bus.count, bus.dst_valid);
        end
        $display("[TB] overflow done");
    endtask

    task automatic test_orphan();
        int c0;
        do_reset();
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_err_cleared: err=%b required 0", bus.err);
        end
        c0 = credit_cnt;
        bus.out_ready = 1'b1;
        push(mk(2'b00, 3'd1, 3'd1, 24'h00BEEF), 1'b0);
        tests_run++;
        if (bus.count !== 3'd1 || bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_T1: count=%0d ov=%b err=%b required 1,0,0", bus.count, bus.out_valid, bus.err);
        end
        cyc();
        tests_run++;
        if ({bus.count, bus.err, bus.credit_out, bus.out_valid, bus.dst_valid} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL t4_T2: count=%0d err=%b credit=%b ov=%b dv=%b required 0,1,1,0,0",
                     bus.count, bus.err, bus.credit_out, bus.out_valid, bus.dst_valid);
        end
        cyc();
        cyc();
        tests_run++;
        if (credit_cnt - c0 != 1) begin
            tests_failed++;
            $display("FAIL t4_credits: got %0d pulses required 1", credit_cnt - c0);
        end
        $display("[TB] orphan body done");
    endtask

    task automatic test_reset_mid_packet();
        int c0;
        do_reset();
        push(mk(2'b01, 3'd2, 3'd3, 24'h000201), 1'b1);
        push(mk(2'b00, 3'd0, 3'd0, 24'h000202), 1'b1);
        cyc();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.count !== 3'd2) begin
            tests_failed++;
            $display("FAIL t5_active: ov=%b count=%0d required 1/2", bus.out_valid, bus.count);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        tests_run++;
        if ({bus.count, bus.out_valid, bus.dst_valid, bus.credit_out} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL t5_after_rst: count=%0d ov=%b dv=%b credit=%b required 0,0,0,0",
                     bus.count, bus.out_valid, bus.dst_valid, bus.credit_out);
        end
        c0 = credit_cnt;
        bus.out_ready = 1'b1;
        push(mk(2'b11, 3'd1, 3'd1, 24'h000203), 1'b1);
        drain(20);
        cyc();
        cyc();
        tests_run++;
        if (credit_cnt - c0 != 1 || bus.dst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_recover: credits=%0d dv=%b required 1/0", credit_cnt - c0, bus.dst_valid);
        end
        $display("[TB] reset mid-packet done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] f [5];
        int  idx = 0;
        int  gap = 0;
        bit  pending = 0;
        bit  gap_done = 0;
        f[0] = mk(2'b01, 3'd2, 3'd0, 24'h000301);
        f[1] = mk(2'b00, 3'd0, 3'd0, 24'h000302);
        f[2] = mk(2'b10, 3'd0, 3'd0, 24'h000303);
        f[3] = mk(2'b01, 3'd0, 3'd3, 24'h000304);
        f[4] = mk(2'b10, 3'd0, 3'd0, 24'h000305);
        for (int n = 0; n < 300; n++) begin
            if (idx == 5 && exp_q.size() == 0) break;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (pending) begin
                if (bus.out_valid === 1'b1) begin
                    tests_run++;
                    if (gap != 2) begin
                        tests_failed++;
                        $display("FAIL t6_gap: got %0d bubble cycles required 2", gap);
                    end
                    pending  = 0;
                    gap_done = 1;
                end else begin
                    gap++;
                end
            end
            if (!gap_done && !pending && bus.out_valid === 1'b1 && bus.out_ready === 1'b1
                && bus.out_flit === f[2]) begin
                pending = 1;
            end
            if (idx < 5 && bus.count < 3'd4) begin
                bus.in_valid = 1'b1;
                bus.in_flit  = f[idx];
                exp_q.push_back(f[idx]);
                idx++;
            end else begin
                bus.in_valid = 1'b0;
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (idx != 5 || exp_q.size() != 0 || !gap_done) begin
            tests_failed++;
            $display("FAIL t6_complete: pushed=%0d left=%0d gap_seen=%0d required 5,0,1",
                     idx, exp_q.size(), gap_done);
        end
        $display("[TB] back-to-back done");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_flit();
        test_packet();
        test_overflow();
        test_orphan();
        test_reset_mid_packet();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
